// File: rtl/seq_divider.sv
// Iterative restoring unsigned divider.
// Resolves one quotient bit per clock under a start/busy/done handshake.
// A zero divisor takes a one-cycle check state and completes with
// quotient all-ones, remainder = dividend and div_by_zero set.
module seq_divider #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             zero
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_ZCHK,
        S_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] rem_q;      // partial remainder R
    logic [WIDTH-1:0] quo_q;      // dividend shifting out / quotient shifting in (Q)
    logic [WIDTH-1:0] dsr_q;      // latched divisor
    logic [CNTW-1:0]  cnt;

    logic [WIDTH:0]   t_ext;      // shifted remainder, one bit wider than R
    logic [WIDTH:0]   diff;       // T - divisor, keeps the borrow in the top bit
    logic             borrow;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;
    logic             last_iter;

    // One restoring step: shift in the next dividend bit, trial-subtract the divisor.
    // R[WIDTH-1] is always 0 before the shift (R holds at most cnt dividend bits
    // and cnt <= WIDTH-1), so shifting the full R equals shifting R[WIDTH-2:0].
    always_comb begin
        t_ext     = {rem_q, quo_q[WIDTH-1]};
        diff      = t_ext - {1'b0, dsr_q};
        borrow    = diff[WIDTH];
        rem_nxt   = borrow ? t_ext[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_nxt   = {quo_q[WIDTH-2:0], ~borrow};
        last_iter = (cnt == CNTW'(WIDTH - 1));
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block ordering.
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (divisor == '0) ? S_ZCHK : S_RUN;
                end
            end
            S_RUN:   if (last_iter) state_nxt = S_DONE;
            S_ZCHK:  state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        busy = (state != S_IDLE);
        done = (state == S_DONE);
    end

    // Working registers and result registers; results change only on completion.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: working registers are cleared too, so an aborted divide
            // leaves no stale partial state behind.
            rem_q       <= '0;
            quo_q       <= '0;
            dsr_q       <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            zero        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        rem_q <= '0;
                        quo_q <= dividend;
                        dsr_q <= divisor;
                        cnt   <= '0;
                    end
                end
                S_RUN: begin
                    rem_q <= rem_nxt;
                    quo_q <= quo_nxt;
                    cnt   <= cnt + CNTW'(1);
                    if (last_iter) begin
                        quotient    <= quo_nxt;
                        remainder   <= rem_nxt;
                        zero        <= (quo_nxt == '0);
                        div_by_zero <= 1'b0;
                    end
                end
                S_ZCHK: begin
                    // Q still holds the latched dividend here.
                    quotient    <= '1;
                    remainder   <= quo_q;
                    div_by_zero <= 1'b1;
                    zero        <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: a transaction-level model predicts
// every output on every cycle; directed cases pin the model with literals.
module tb_seq_divider;

    localparam int WIDTH = 32;

    logic             clk;
    logic             reset_n;
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             zero;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    seq_divider #(.WIDTH(WIDTH), .CNTW(6)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .zero        (zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // An accepted request completes one edge later for divisor 0, WIDTH edges
    // later otherwise; the unit is busy until the edge after completion.
    int unsigned      edge_cnt;
    int unsigned      m_done_edge;
    bit               m_active;
    logic [WIDTH-1:0] m_dd, m_dv;
    logic             exp_busy, exp_done, exp_dz, exp_zero;
    logic [WIDTH-1:0] exp_q, exp_r;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_active = 0;
            exp_busy = 0; exp_done = 0; exp_dz = 0; exp_zero = 0;
            exp_q = '0; exp_r = '0;
        end else begin
            edge_cnt++;
            exp_done = 0;
            if (!m_active) begin
                if (start) begin
                    m_active    = 1;
                    m_dd        = dividend;
                    m_dv        = divisor;
                    m_done_edge = edge_cnt + ((divisor == 0) ? 1 : WIDTH);
                end
            end else if (edge_cnt == m_done_edge) begin
                exp_done = 1;
                if (m_dv == 0) begin
                    exp_q = '1; exp_r = m_dd; exp_dz = 1; exp_zero = 0;
                end else begin
                    exp_q = m_dd / m_dv; exp_r = m_dd % m_dv; exp_dz = 0;
                    exp_zero = (exp_q == 0);
                end
            end else if (edge_cnt == m_done_edge + 1) begin
                m_active = 0;
            end
            exp_busy = m_active;
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", busy, exp_busy);
            check("done", done, exp_done);
            check("quotient", quotient, exp_q);
            check("remainder", remainder, exp_r);
            check("div_by_zero", div_by_zero, exp_dz);
            check("zero", zero, exp_zero);
            if (exp_done && m_dv != 0) begin
                check("invariant", 64'(quotient) * 64'(m_dv) + 64'(remainder), 64'(m_dd));
                check("rem_lt_div", remainder < m_dv, 1);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    int lat, bcnt;

    // Called at the negedge just after the accepting edge; returns at the
    // negedge of the done cycle. lat = edges after acceptance until DONE.
    task automatic wait_done(output int l, output int b);
        l = 0;
        b = 0;
        while (1) begin
            if (busy) b++;
            if (done) break;
            if (l >= 100) begin
                check("done_timeout", done, 1);
                break;
            end
            l++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input logic [WIDTH-1:0] dd, input logic [WIDTH-1:0] dv,
                          output int l, output int b);
        @(negedge clk);
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(l, b);
    endtask

    initial begin
        int done_seen;
        logic [WIDTH-1:0] rdd, rdv;
        start = 0; dividend = '0; divisor = '0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #2;
        chk_en = 1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_dbz", div_by_zero, 0);
        check("rst_zero", zero, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Basic divide
        run_op(32'd100, 32'd7, lat, bcnt);
        check("basic_latency", lat, WIDTH);
        check("basic_busy_cycles", bcnt, WIDTH + 1);
        check("basic_q", quotient, 14);
        check("basic_r", remainder, 2);
        check("basic_zero", zero, 0);
        check("basic_dbz", div_by_zero, 0);

        // Reset mid-RUN after 10 iterations
        @(negedge clk);
        dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_quotient", quotient, 0);
        check("abort_remainder", remainder, 0);
        check("abort_dbz", div_by_zero, 0);
        check("abort_zero", zero, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("abort_no_done", done_seen, 0);
        check("abort_idle", busy, 0);

        // Boundaries
        run_op(32'hFFFF_FFFF, 32'd1, lat, bcnt);
        check("max_div1_q", quotient, 32'hFFFF_FFFF);
        check("max_div1_r", remainder, 0);
        run_op(32'd5, 32'd9, lat, bcnt);
        check("small_q", quotient, 0);
        check("small_r", remainder, 5);
        check("small_zero", zero, 1);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
        check("msb_q", quotient, 0);
        check("msb_r", remainder, 32'h8000_0000);

        // Divide by zero
        run_op(32'd1234, 32'd0, lat, bcnt);
        check("dbz_latency", lat, 1);
        check("dbz_busy_cycles", bcnt, 2);
        check("dbz_q", quotient, 32'hFFFF_FFFF);
        check("dbz_r", remainder, 32'd1234);
        check("dbz_flag", div_by_zero, 1);
        check("dbz_zero", zero, 0);

        // start held with new operands through RUN and DONE is ignored,
        // then accepted in the IDLE cycle after done.
        @(negedge clk);
        dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        @(negedge clk);
        dividend = 32'd50; divisor = 32'd5;
        wait_done(lat, bcnt);
        check("hs_latency", lat, WIDTH);
        check("hs_q", quotient, 14);
        check("hs_r", remainder, 2);
        @(negedge clk);
        check("hs_idle_gap", busy, 0);
        @(negedge clk);
        start = 1'b0;
        check("b2b_accepted", busy, 1);
        wait_done(lat, bcnt);
        check("b2b_latency", lat, WIDTH);
        check("b2b_q", quotient, 10);
        check("b2b_r", remainder, 0);
        check("b2b_zero", zero, 0);

        // Random operand pairs, ~10% zero divisors
        for (int i = 0; i < 1000; i++) begin
            rdd = $urandom;
            if ($urandom_range(0, 9) == 0) begin
                rdv = '0;
            end else begin
                rdv = $urandom >> $urandom_range(0, 31);
                if (rdv == 0) rdv = 1;
            end
            run_op(rdd, rdv, lat, bcnt);
            check("rand_latency", lat, (rdv == 0) ? 1 : WIDTH);
        end

        repeat (3) @(negedge clk);
        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
